tile_rom_arbiter: RTL
=====================

TILE_ROM_ARBITER -- requirements
Module: tile_rom_arbiter

Interface
REQ-001 Parameter ADDR_W, default 10, tile ROM address width.
REQ-002 Parameter DATA_W, default 12, pixel word width (4-4-4 RGB).
REQ-003 Parameter TILE_PIXELS, default 576, valid addresses per tile (24x24).
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 req[1:0]  input  2  per-requester read request (0 = background renderer, 1 = sprite renderer).
REQ-007 tsel[1:0]  input  2  per-requester tile select (0 = ground, 1 = platform).
REQ-008 addr0, addr1  input  ADDR_W each  per-requester pixel address.
REQ-009 gnt[1:0]  output  2  combinational grant; a request is accepted when req[i] && gnt[i].
REQ-010 rvalid[1:0]  output  2  one-cycle pulse; read data for requester i is on rdata.
REQ-011 rdata  output  DATA_W  returned pixel; 0 when rvalid is all-zero.
REQ-012 oor[1:0]  output  2  one-cycle pulse, coincident with rvalid; accepted address was >= TILE_PIXELS.
REQ-013 rom_addr  output  ADDR_W  registered address to both tile ROMs.
REQ-014 rom_ground_data, rom_platform_data  input  DATA_W each  ROM outputs, registered, 1-cycle latency.

Function
REQ-015 At most one gnt bit SHALL be high per cycle, and only for a requester with req high.
REQ-016 Arbitration SHALL be round-robin: with both requesting, the requester not granted most recently wins.
REQ-017 The last-granted pointer SHALL update only on an accepted request; after reset it SHALL point to requester 1, so requester 0 wins the first tie.
REQ-018 A sole requester SHALL be granted every cycle (full throughput, one accept per cycle).
REQ-019 Accept at cycle N SHALL register rom_addr at the end of N; ROM data SHALL be ready at N+2; rvalid[i] and rdata SHALL assert at cycle N+2 (fixed latency 2).
REQ-020 A two-stage pipeline SHALL carry {valid, requester id, tsel, oor} alongside each access; back-to-back accepts SHALL return in accept order without bubbles.
REQ-021 rdata SHALL be rom_ground_data when the stage-2 tsel is 0, and rom_platform_data when it is 1.
REQ-022 An address >= TILE_PIXELS SHALL still be accepted and shall not drive the ROM with it: rom_addr SHALL be 0, rdata SHALL be forced to 0, and oor[i] SHALL pulse with rvalid[i].
REQ-023 rom_addr SHALL hold its last value when nothing is accepted.
REQ-024 Address comparison SHALL be unsigned, ADDR_W wide; TILE_PIXELS-1 (575) is in range and 576 is out of range.
REQ-025 Requesters are not required to hold req; dropping req without a grant SHALL have no effect.

Reset
REQ-026 Asserting rst_n low SHALL immediately clear gnt, rvalid, oor, rdata, rom_addr and all pipeline valid bits, and set the pointer to 1.
REQ-027 Reads in flight at reset SHALL be discarded; no rvalid for them after release.
REQ-028 The first accept SHALL occur no earlier than the first rising edge with rst_n high.

Structure
REQ-029 Package tile_pkg SHALL hold TILE_W=24, TILE_PIXELS=576, ADDR_W, DATA_W, and the tile ids TILE_GROUND=0 and TILE_PLATFORM=1.
REQ-030 The arbitration SHALL be a sub-module rr_arb2 (req[1:0], accept -> gnt[1:0], pointer flop); the pipeline and mux SHALL stay in tile_rom_arbiter.

Verification
REQ-031 Single requester: req0=1, tsel0=0, addr0=5, 10, 575 in consecutive cycles -> gnt0 each cycle; rvalid0 at N+2, N+3 and N+4 with ground[5], ground[10] and ground[575].
REQ-032 Contention: req=2'b11 held 4 cycles after reset -> grant order 0,1,0,1; rvalid follows the same order 2 cycles later with the correct tile data per tsel.
REQ-033 Out of range: req1=1, tsel1=1, addr1=576 -> rvalid1 and oor1 pulse at N+2, rdata=0; addr1=1023 behaves the same.
REQ-034 Tile mux: alternate tsel0 0,1,0 at addr0=100 -> rdata = ground[100], platform[100], ground[100].
REQ-035 Reset mid-flight: accepts at N and N+1, rst_n low during N+1, released at N+3 -> no rvalid at N+2 through N+4; the next tie grants requester 0.
REQ-036 Idle hold: no req for 3 cycles after accepting addr=42 -> rom_addr stays 42, gnt and rvalid stay 0.

Source files
------------

// File: rtl/tile_pkg.sv
// ---------------------------------------------------------------------------
// tile_pkg
// Shared constants and types for the tile ROM arbiter.
//   TILE_W / TILE_PIXELS : tile geometry (24x24 = 576 pixel words per tile)
//   ADDR_W / DATA_W      : default ROM address width and 4-4-4 RGB word width
//   TILE_GROUND/PLATFORM : tile select encodings carried with each access
//   pipe_t               : side-band carried down the two read stages
// ---------------------------------------------------------------------------
package tile_pkg;

    localparam int TILE_W      = 24;
    localparam int TILE_PIXELS = TILE_W * TILE_W;
    localparam int ADDR_W      = 10;
    localparam int DATA_W      = 12;

    localparam logic TILE_GROUND   = 1'b0;
    localparam logic TILE_PLATFORM = 1'b1;

    // valid : stage holds a real access
    // id    : requester that owns the access (0 = background, 1 = sprite)
    // tsel  : tile the data must be taken from
    // oor   : address was out of range, data is forced to zero
    typedef struct packed {
        logic valid;
        logic id;
        logic tsel;
        logic oor;
    } pipe_t;

endpackage

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter with a last-granted pointer.
//   clk, rst_n : clock, asynchronous active-low reset
//   req[1:0]   : request per requester
//   accept     : a granted request was taken this cycle (advances pointer)
//   gnt[1:0]   : combinational one-hot (or zero) grant
// On a tie the requester that was not granted most recently wins. The
// pointer resets to requester 1 so requester 0 wins the first tie.
// Handshake: a request is accepted in the cycle where req[i] && gnt[i]; req
// may be dropped at any time without side effects.
// ---------------------------------------------------------------------------
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt
);

    logic r_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= 1'b1;
        end else if (accept) begin
            r_last <= gnt[1];
        end
    end

    // Grant is masked by reset so nothing can be taken while rst_n is low.
    always_comb begin
        gnt = 2'b00;
        if (rst_n) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = r_last ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/tile_rom_arbiter.sv
// ---------------------------------------------------------------------------
// tile_rom_arbiter
// Shares the ground and platform tile ROMs between the background renderer
// (requester 0) and the sprite renderer (requester 1).
//   clk, rst_n         : clock, asynchronous active-low reset
//   req[1:0]           : read request per requester
//   tsel[1:0]          : tile select per requester (0 ground, 1 platform)
//   addr0, addr1       : pixel address per requester
//   gnt[1:0]           : combinational grant, accept = req[i] && gnt[i]
//   rvalid[1:0]        : one-cycle return pulse, two cycles after accept
//   rdata              : returned pixel, zero when nothing returns
//   oor[1:0]           : pulses with rvalid when the address was >= TILE_PIXELS
//   rom_addr           : registered address shared by both ROMs
//   rom_ground_data,
//   rom_platform_data  : registered ROM outputs (one-cycle latency)
// Timing: accept in cycle N registers rom_addr at the end of N, the ROMs
// register their data at the end of N+1, and the return is presented in N+2.
// ---------------------------------------------------------------------------
module tile_rom_arbiter #(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 12,
    parameter int TILE_PIXELS = 576
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req,
    input  logic [1:0]        tsel,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    output logic [1:0]        gnt,
    output logic [1:0]        rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        oor,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_ground_data,
    input  logic [DATA_W-1:0] rom_platform_data
);

    import tile_pkg::*;

    // One extra bit keeps the limit exact even if TILE_PIXELS == 2**ADDR_W.
    localparam logic [ADDR_W:0] PIX_LIM = (ADDR_W + 1)'(TILE_PIXELS);

    logic [1:0]        w_gnt;
    logic [1:0]        w_acc;
    logic              w_accept;
    logic              w_id;
    logic [ADDR_W-1:0] w_addr;
    logic              w_tsel;
    logic              w_oor;

    pipe_t             r_s1;
    pipe_t             r_s2;
    logic [ADDR_W-1:0] r_rom_addr;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .accept (w_accept),
        .gnt    (w_gnt)
    );

    assign gnt      = w_gnt;
    assign w_acc    = req & w_gnt;
    assign w_accept = |w_acc;
    assign w_id     = w_acc[1];
    assign w_addr   = w_id ? addr1 : addr0;
    assign w_tsel   = tsel[w_id];
    assign w_oor    = {1'b0, w_addr} >= PIX_LIM;

    // Stage 1 lines up with the ROM address register, stage 2 with the ROM
    // data register. An out-of-range access parks the ROM at address 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1       <= '0;
            r_s2       <= '0;
            r_rom_addr <= '0;
        end else begin
            r_s1 <= '{valid: w_accept, id: w_id, tsel: w_tsel, oor: w_oor};
            r_s2 <= r_s1;
            if (w_accept) begin
                r_rom_addr <= w_oor ? '0 : w_addr;
            end
        end
    end

    assign rom_addr = r_rom_addr;

    always_comb begin
        rvalid = 2'b00;
        oor    = 2'b00;
        rdata  = '0;
        if (r_s2.valid) begin
            rvalid[r_s2.id] = 1'b1;
            oor[r_s2.id]    = r_s2.oor;
            if (!r_s2.oor) begin
                rdata = (r_s2.tsel == TILE_PLATFORM) ? rom_platform_data
                                                     : rom_ground_data;
            end
        end
    end

endmodule
